// File: rtl/alu_share_if.sv
// rtl/alu_share_if.sv - requester/result bus between two requesters and the shared ALU
//
// Ports (signals):
//   req0/req1        request from requester 0/1, held until acknowledged
//   op0/op1          3-bit opcode from requester 0/1
//   a0/b0, a1/b1     WIDTH-bit signed operands from requester 0/1
//   gnt              one-hot grant of the operation in flight
//   ack0/ack1        single-cycle completion strobe per requester
//   result, zero     registered result of the last completed operation and its zero flag
//   busy             high whenever the sequencer is not idle
// Modports: master = requester side, slave = arbiter side.
interface alu_share_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt, ack0, ack1, result, zero, busy
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt, ack0, ack1, result, zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one ALU between two requesters
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_if.slave: requests/opcodes/operands in; grant, acks,
//          registered result, zero flag and busy out
// Sequence: IDLE (sample and latch winner) -> EXEC (register ALU output)
//           -> DONE (ack strobe) -> IDLE.
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       gnt_q;
  logic             last_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             any_req;
  logic             winner;
  logic [WIDTH-1:0] alu_y;

  assign any_req = bus.req0 | bus.req1;

  // Under contention the requester that did not win last time goes next;
  // otherwise the lone requester wins (req1 alone -> 1, req0 alone -> 0).
  assign winner = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  // Two's complement add/sub truncate naturally to WIDTH bits.
  always_comb begin
    alu_y = '0;
    case (op_q)
      3'b000:  alu_y = b_q;
      3'b001:  alu_y = a_q + b_q;
      3'b010:  alu_y = a_q & b_q;
      3'b011:  alu_y = a_q | b_q;
      3'b100:  alu_y = a_q - b_q;
      default: alu_y = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers, loaded at the transition edges of the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_q   <= winner ? bus.op1 : bus.op0;
            a_q    <= winner ? bus.a1  : bus.a0;
            b_q    <= winner ? bus.b1  : bus.b0;
            gnt_q  <= winner ? 2'b10   : 2'b01;
            last_q <= winner;
          end
        end
        EXEC: begin
          result_q <= alu_y;
          zero_q   <= (alu_y == '0);
        end
        DONE: begin
          gnt_q <= '0;
        end
        default: begin
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Output logic: the ack strobe is the DONE state qualified by the held grant,
  // so it lasts exactly one cycle and the two acks can never coincide.
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.ack0   = (state == DONE) & gnt_q[0];
    bus.ack1   = (state == DONE) & gnt_q[1];
    bus.gnt    = gnt_q;
    bus.result = result_q;
    bus.zero   = zero_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_share_if #(.WIDTH(8)) bus ();

  alu_share_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int who, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (who == 0) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
  endtask

  // One isolated operation: request, then check grant/ack/idle on the
  // three following falling edges.
  task automatic run_op(input string tag, input int who, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    logic [7:0] prev;
    prev = bus.result;
    @(negedge clk);
    drive(who, op, a, b);
    @(negedge clk);
    check({tag, "_gnt"}, 32'(bus.gnt), (who == 0) ? 32'd1 : 32'd2);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_hold"}, 32'(bus.result), 32'(prev));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check({tag, "_ack0"}, 32'(bus.ack0), (who == 0) ? 32'd1 : 32'd0);
    check({tag, "_ack1"}, 32'(bus.ack1), (who == 1) ? 32'd1 : 32'd0);
    check({tag, "_res"}, 32'(bus.result), 32'(exp));
    check({tag, "_zero"}, 32'(bus.zero), (exp == 8'd0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {bus.busy, bus.gnt, bus.ack0, bus.ack1}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0  = '0;   bus.op1  = '0;
    bus.a0   = '0;   bus.b0   = '0;
    bus.a1   = '0;   bus.b1   = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res", 32'(bus.result), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    rst_n = 1'b1;

    // Single ops
    run_op("and0", 0, 3'b010, 8'b11010100, 8'd10, 8'd0);
    run_op("and1", 0, 3'b010, 8'd15, 8'd11, 8'd11);
    run_op("mov", 1, 3'b000, 8'h33, 8'h5a, 8'h5a);
    run_op("or", 0, 3'b011, 8'h0f, 8'hf0, 8'hff);

    // Reset in the middle of EXEC
    @(negedge clk);
    drive(0, 3'b001, 8'd3, 8'd4);
    @(negedge clk);
    check("mid_gnt", 32'(bus.gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst", {bus.busy, bus.gnt, bus.ack0, bus.ack1}, 32'd0);
    check("mid_res", 32'(bus.result), 32'd0);
    check("mid_zero", 32'(bus.zero), 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("mid_noack", {bus.ack0, bus.ack1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {bus.busy, bus.gnt, bus.ack0, bus.ack1}, 32'd0);
    check("post_res", 32'(bus.result), 32'd0);
    check("post_zero", 32'(bus.zero), 32'd1);

    // Contention: LAST is 1 after reset, so grants go 0,1,0,1
    drive(0, 3'b001, 8'd1, 8'd1);
    drive(1, 3'b011, 8'h30, 8'h03);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cont_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      check("cont_acks", {bus.ack0, bus.ack1}, (k % 2 == 0) ? 32'd2 : 32'd1);
      check("cont_res", 32'(bus.result), (k % 2 == 0) ? 32'd2 : 32'h33);
      @(negedge clk);
      check("cont_idle", 32'(bus.busy), 32'd0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Arithmetic wrap and reserved opcode
    run_op("add_wrap", 1, 3'b001, 8'd127, 8'd1, 8'h80);
    run_op("sub_wrap", 1, 3'b100, 8'h80, 8'd1, 8'h7f);
    run_op("rsvd", 1, 3'b110, 8'h12, 8'h34, 8'h00);

    // Late change: operands altered and REQ dropped after latching
    @(negedge clk);
    drive(0, 3'b001, 8'd10, 8'd5);
    @(negedge clk);
    check("late_gnt", 32'(bus.gnt), 32'd1);
    bus.a0   = 8'd100;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("late_ack", 32'(bus.ack0), 32'd1);
    check("late_res", 32'(bus.result), 32'd15);
    @(negedge clk);
    check("late_idle", 32'(bus.busy), 32'd0);

    // Back-to-back: REQ0 held through the ack
    @(negedge clk);
    drive(0, 3'b000, 8'd0, 8'h42);
    @(negedge clk);
    check("b2b_gnt1", 32'(bus.gnt), 32'd1);
    @(negedge clk);
    check("b2b_ack1", 32'(bus.ack0), 32'd1);
    check("b2b_res1", 32'(bus.result), 32'h42);
    bus.b0 = 8'h24;
    @(negedge clk);
    check("b2b_gap", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    check("b2b_gnt2", 32'(bus.gnt), 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("b2b_ack2", 32'(bus.ack0), 32'd1);
    check("b2b_res2", 32'(bus.result), 32'h24);
    @(negedge clk);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and two-way arbiter that shares one 8-bit ALU between two requesters, e.g. the instruction datapath and a debug/test port. Each requester presents an opcode and two operands and holds a request until acknowledged. The block picks a winner round-robin, latches its operands, runs the operation through the internal ALU, and returns a registered result with a one-cycle acknowledge. It sits between the register-file read ports and the write-back path.

## Interface
- WIDTH, 8, operand/result width in bits
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- REQ0, REQ1  input  1  request from requester 0 / 1
- OP0, OP1  input  3  opcode from requester 0 / 1
- A0, B0, A1, B1  input  WIDTH  signed operands from requester 0 / 1
- GNT  output  2  one-hot grant of the operation in flight (bit n = requester n)
- ACK0, ACK1  output  1  single-cycle completion strobe to requester 0 / 1
- RESULT  output  WIDTH  registered result of the last completed operation
- ZERO  output  1  registered flag, 1 when RESULT == 0
- BUSY  output  1  high whenever state != IDLE

## Operation
- Opcodes: 000 MOV (RESULT = B), 001 ADD (A+B), 010 AND (A&B bitwise), 011 OR (A|B), 100 SUB (A−B), 101–111 reserved (RESULT = 0, ZERO = 1).
- ADD/SUB are two's complement, truncated to WIDTH bits (wrap-around, no carry or overflow output).
- FSM states: IDLE, EXEC, DONE.
  - IDLE → EXEC when REQ0 or REQ1 is sampled high. At that edge: winner's OP/A/B latched, GNT set, LAST updated.
  - EXEC → DONE unconditionally. At that edge: ALU output on the latched operands is registered into RESULT and ZERO, and the winner's ACK is set.
  - DONE → IDLE unconditionally. At that edge: ACK and GNT cleared.
- Arbitration: if only one REQ is high, that requester wins. If both are high, the requester that is not LAST wins. LAST resets to 1, so requester 0 wins the first contention.
- Requester must hold REQ and stable OP/A/B until its operands are latched. Changes after latching have no effect.
- REQ dropped during EXEC/DONE: the operation still completes and ACK is still issued (no abort).
- REQ still high in the cycle after ACK: treated as a new request at the next IDLE sample.
- Requests arriving while BUSY wait. They are never lost as long as REQ is held.

## Timing
- Reset (asynchronous, RESET_N low): state = IDLE, GNT = 00, ACK0 = ACK1 = 0, RESULT = 0, ZERO = 1, BUSY = 0, LAST = 1, operand registers = 0. An operation in flight is discarded with no ACK.
- REQ sampled at edge t → GNT and BUSY high after t → ACK high for exactly the cycle between t+1 and t+2 → IDLE after t+2.
- Latency is 2 cycles from request sample to ACK. Peak throughput is one operation per 3 cycles.
- RESULT/ZERO change only at the EXEC→DONE edge (or reset). Otherwise they hold.
- ACK0 and ACK1 are never high together. GNT is one-hot or zero.
- RESET_N release is synchronous to CLK, with no request sampled in the release cycle.

## Test plan
- Reset: drive RESET_N low mid-EXEC → all outputs at reset values immediately, no ACK. After release, RESULT = 0 and ZERO = 1.
- Single op: REQ0, OP0 = 010, A0 = 8'b11010100, B0 = 10 → GNT = 01, then ACK0 two cycles after the request sample, with RESULT = 0 and ZERO = 1. Repeat with A0 = 15, B0 = 11 → RESULT = 11.
- Arithmetic wrap: REQ1, ADD, A1 = 127, B1 = 1 → RESULT = −128. SUB, A1 = −128, B1 = 1 → RESULT = 127. Reserved opcode 110 → RESULT = 0.
- Contention: REQ0 and REQ1 both held high continuously → grants alternate 0,1,0,1 with ACK0/ACK1 every 3 cycles, never simultaneous.
- Late change: after the grant, change A0 and drop REQ0 during EXEC → ACK0 is still issued, with RESULT computed from the originally latched operands.
- Back-to-back: REQ0 held high through its ACK → second operation granted at the next IDLE sample. BUSY low for exactly one cycle between the two operations.
